pp_sum_norm: RTL and testbench
==============================

# pp_sum_norm

Consumer end of the multiplier-to-adder pipeline register: accepts one registered set of thirteen 49-bit partial products plus sign and pre-normalization exponent, sums them sequentially, normalizes, and emits a packed IEEE-754 single-precision product. Sits directly downstream of the partial-product register stage and upstream of the result writeback. Uses a valid/ready handshake on both sides and processes one operation at a time.

## Interface
- NUM_PP, 13, partial products summed per operation; fixed at 13 in this revision.
- PP_W, 49, partial-product and accumulator width.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; one clock; asynchronous, active-high.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block idle, can accept.
- P0..P12  input  49 each  partial products, unsigned.
- sign  input  1  result sign.
- expc  input  9  biased exponent before normalization, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- result  output  32  packed single-precision value.
- ovf  output  1  result saturated to infinity.

## Operation
- FSM states: IDLE, ACC, NORM, OUT.
- IDLE: in_ready=1. On in_valid&in_ready: capture P0..P12, sign, expc into local registers; acc<=0; idx<=0; go to ACC.
- ACC: each cycle acc <= acc + pp[idx], idx <= idx+1; after adding pp[12], go to NORM. Addition is modulo 2^49; bit 48 is ignored by normalization.
- NORM (one cycle): if acc[47:0]==0 → result={sign,31'b0}, ovf=0. Else if acc[47]=1 → mant=acc[46:24], guard=acc[23], sticky=|acc[22:0], e=expc+1. Else → mant=acc[45:23], guard=acc[22], sticky=|acc[21:0], e=expc. (acc[47:46]==00 with nonzero acc is treated as the acc[47]=0 case, no further shift.)
- Rounding per Configuration; a mantissa carry-out sets mant=0, e=e+1.
- Exponent checks, computed in 10 bits after rounding: e>=255 → result={sign,8'hFF,23'b0}, ovf=1. e==0 → result={sign,31'b0}, ovf=0 (flush). Else result={sign,e[7:0],mant}, ovf=0.
- NORM registers result/ovf, sets out_valid=1, and goes to OUT.
- OUT: hold result, ovf, and out_valid until out_ready=1, then out_valid<=0 and go to IDLE. in_valid is ignored outside IDLE.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, ovf=0, acc=0, idx=0.
- Acceptance edge T → 13 ACC edges → NORM edge at T+14 → out_valid high from T+14.
- Minimum occupancy is 16 cycles per operation with out_ready held high. There is no overlap: the next acceptance is no earlier than the cycle after the out_ready handshake.
- in_ready is a decode of state==IDLE. result and ovf are stable for the whole time out_valid is high.
- Reset asserted in any state aborts the operation immediately: out_valid=0, in_ready=1 from the reset edge, and no partial result is emitted.
- in_valid held high while not IDLE has no effect; the input data is not captured.

## Configuration
- PP_SUM_RNE_EN defined: round to nearest, ties to even: increment when guard&(sticky|mant[0]).
- Undefined: truncate. guard and sticky are discarded. Latency is identical in both builds.

## Test plan
- 1.0×1.0: P0=0x400000000000, others 0, sign=0, expc=127 → result=0x3F800000, ovf=0, out_valid at T+14.
- 1.5×1.5 split: P0=0x800000000000, P5=0x100000000000, expc=127 → result=0x40100000 (2.25).
- Rounding tie: P0=0x400000C00000, expc=127 → 0x3F800002 with PP_SUM_RNE_EN defined, 0x3F800001 without.
- Overflow and zero: the 1.5×1.5 case with expc=254 → 0x7F800000, ovf=1. All P=0 with sign=1 → 0x80000000.
- Backpressure: out_ready=0 for 10 cycles after out_valid → result held, in_ready=0, in_valid pulses ignored. Release → IDLE the next cycle.
- Reset mid-ACC: assert rst 5 cycles after acceptance → out_valid=0 and in_ready=1 immediately. The next operation (1.0×1.0) completes correctly.

Source files
------------

// File: rtl/pp_sum_norm.sv
// pp_sum_norm
//   Receives one registered set of NUM_PP unsigned partial products, plus the
//   result sign and the pre-normalization biased exponent. It adds the partial
//   products one per cycle into a PP_W-bit accumulator. It then normalizes and
//   rounds the sum and emits a packed IEEE-754 single-precision value. Only one
//   operation is in flight at a time.
//
//   Build option: define PP_SUM_RNE_EN to select round-to-nearest-even.
//   When it is not defined, the result is truncated. Latency is the same in
//   both builds.
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous active-high reset
//     in_valid   operand set valid
//     in_ready   block idle and able to accept (decode of IDLE)
//     p0..p12    partial products, unsigned, PP_W bits
//     sign       result sign
//     expc       biased exponent before normalization (9 bits)
//     out_valid  result valid
//     out_ready  downstream accepts result
//     result     packed single-precision result
//     ovf        result saturated to infinity
module pp_sum_norm #(
    parameter int NUM_PP = 13,
    parameter int PP_W   = 49
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PP_W-1:0] p0,
    input  logic [PP_W-1:0] p1,
    input  logic [PP_W-1:0] p2,
    input  logic [PP_W-1:0] p3,
    input  logic [PP_W-1:0] p4,
    input  logic [PP_W-1:0] p5,
    input  logic [PP_W-1:0] p6,
    input  logic [PP_W-1:0] p7,
    input  logic [PP_W-1:0] p8,
    input  logic [PP_W-1:0] p9,
    input  logic [PP_W-1:0] p10,
    input  logic [PP_W-1:0] p11,
    input  logic [PP_W-1:0] p12,
    input  logic            sign,
    input  logic [8:0]      expc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     result,
    output logic            ovf
);

    localparam int IDX_W = $clog2(NUM_PP);
    // Highest accumulator bit that normalization looks at. The top bit
    // (PP_W-1) is a wrap-around bit and is ignored.
    localparam int TOP   = PP_W - 2;

    typedef enum logic [1:0] {IDLE, ACC, NORM, OUT} state_t;

    state_t            state;
    logic [PP_W-1:0]   acc;
    logic [IDX_W-1:0]  idx;

    // Captured operands. This is data only, so it has no reset.
    logic [PP_W-1:0]   pp_q [NUM_PP];
    logic              sign_q;
    logic [8:0]        expc_q;

    // Normalization / rounding datapath (combinational, used in NORM)
    logic              acc_zero;
    logic [22:0]       mant;
    logic              guard;
    logic              sticky;
    logic [9:0]        e_pre;
    logic [9:0]        e_post;
    logic [23:0]       mant_rnd;
    logic [32:0]       norm_word;
    logic              unused_ok;

    // Returns {carry, mantissa}. A carry means the mantissa wrapped to zero.
    function automatic logic [23:0] round_mant(input logic [22:0] m,
                                               input logic        g,
                                               input logic        s);
`ifdef PP_SUM_RNE_EN
        return {1'b0, m} + {23'd0, g & (s | m[0])};
`else
        logic unused_rnd;
        unused_rnd = g ^ s;
        return {1'b0, m};
`endif
    endfunction

    // Returns {ovf, packed result}. The exponent is given after rounding,
    // in 10 bits, so that overflow past 255 can be seen.
    function automatic logic [32:0] pack(input logic        s,
                                         input logic        zero,
                                         input logic [9:0]  e,
                                         input logic [22:0] m);
        if (zero)
            return {1'b0, s, 31'd0};
        if (e >= 10'd255)
            return {1'b1, s, 8'hFF, 23'd0};
        if (e == 10'd0)
            return {1'b0, s, 31'd0};
        return {1'b0, s, e[7:0], m};
    endfunction

    assign in_ready  = (state == IDLE);
    assign unused_ok = acc[PP_W-1];

    always_comb begin
        acc_zero = (acc[TOP:0] == '0);
        if (acc[TOP]) begin
            mant   = acc[TOP-1:TOP-23];
            guard  = acc[TOP-24];
            sticky = |acc[TOP-25:0];
            e_pre  = {1'b0, expc_q} + 10'd1;
        end else begin
            // A leading bit below TOP-1 gets no extra shift. The value is
            // taken as it stands.
            mant   = acc[TOP-2:TOP-24];
            guard  = acc[TOP-25];
            sticky = |acc[TOP-26:0];
            e_pre  = {1'b0, expc_q};
        end
        mant_rnd  = round_mant(mant, guard, sticky);
        e_post    = e_pre + {9'd0, mant_rnd[23]};
        norm_word = pack(sign_q, acc_zero, e_post, mant_rnd[22:0]);
    end

    // Operand capture on acceptance
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            pp_q[0]  <= p0;
            pp_q[1]  <= p1;
            pp_q[2]  <= p2;
            pp_q[3]  <= p3;
            pp_q[4]  <= p4;
            pp_q[5]  <= p5;
            pp_q[6]  <= p6;
            pp_q[7]  <= p7;
            pp_q[8]  <= p8;
            pp_q[9]  <= p9;
            pp_q[10] <= p10;
            pp_q[11] <= p11;
            pp_q[12] <= p12;
            sign_q   <= sign;
            expc_q   <= expc;
        end
    end

    // Control FSM with accumulator and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            idx       <= '0;
            result    <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= '0;
                        idx   <= '0;
                        state <= ACC;
                    end
                end
                ACC: begin
                    acc <= acc + pp_q[idx];
                    idx <= idx + 1'b1;
                    if (idx == IDX_W'(NUM_PP - 1))
                        state <= NORM;
                end
                NORM: begin
                    {ovf, result} <= norm_word;
                    out_valid     <= 1'b1;
                    state         <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pp_sum_norm.sv
// Testbench for pp_sum_norm. The driver pushes each expected {result, ovf}
// into a scoreboard queue. The value is pushed when the operation is driven
// and popped when out_valid appears. Expected values come either from literal
// tables or from an independent reference model of the arithmetic.
module tb_pp_sum_norm;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [48:0] pp_drv [13];
    logic        sign;
    logic [8:0]  expc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pp_sum_norm dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .p0(pp_drv[0]), .p1(pp_drv[1]), .p2(pp_drv[2]), .p3(pp_drv[3]),
        .p4(pp_drv[4]), .p5(pp_drv[5]), .p6(pp_drv[6]), .p7(pp_drv[7]),
        .p8(pp_drv[8]), .p9(pp_drv[9]), .p10(pp_drv[10]), .p11(pp_drv[11]),
        .p12(pp_drv[12]), .sign(sign), .expc(expc),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ovf(ovf)
    );

    // Reference model. It derives the rounding decision from the value of
    // the discarded remainder relative to one half ulp.
    function automatic exp_t model(input logic s, input logic [8:0] ex);
        logic [48:0] sum;
        logic [47:0] a, q, rem, half;
        logic [23:0] m;
        logic [9:0]  e;
        logic        rnd_up;
        int          sh;
        exp_t        r;
        sum = '0;
        for (int i = 0; i < 13; i++) sum = sum + pp_drv[i];
        a = sum[47:0];
        if (a == '0) begin
            r.res = {s, 31'd0};
            r.ovf = 1'b0;
            return r;
        end
        sh     = a[47] ? 24 : 23;
        q      = a >> sh;
        rem    = a - (q << sh);
        half   = 48'd1 << (sh - 1);
        m      = {1'b0, q[22:0]};
        e      = {1'b0, ex} + ((sh == 24) ? 10'd1 : 10'd0);
        rnd_up = (rem > half) || (rem == half && m[0]);
`ifdef PP_SUM_RNE_EN
        if (rnd_up) m = m + 24'd1;
`else
        if (rnd_up && 1'b0) m = m + 24'd1;
`endif
        if (m[23]) begin
            m = 24'd0;
            e = e + 10'd1;
        end
        if (e >= 10'd255) begin
            r.res = {s, 8'hFF, 23'd0};
            r.ovf = 1'b1;
        end else if (e == 10'd0) begin
            r.res = {s, 31'd0};
            r.ovf = 1'b0;
        end else begin
            r.res = {s, e[7:0], m[22:0]};
            r.ovf = 1'b0;
        end
        return r;
    endfunction

    task automatic clear_pp();
        for (int i = 0; i < 13; i++) pp_drv[i] = '0;
    endtask

    // Drive one operand set and return at 1 time unit after the acceptance edge.
    task automatic send(input logic s, input logic [8:0] ex);
        int n;
        n = 0;
        sign     = s;
        expc     = ex;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout in_ready got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges after acceptance until out_valid is seen. The count is bounded.
    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 60);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sign      = 1'b0;
        expc      = '0;
        clear_pp();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, result, ovf} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b res=%h ovf=%b want 1 0 0 0",
                     in_ready, out_valid, result, ovf);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [48:0] pa;
        logic [48:0] pb;
        logic        s;
        logic [8:0]  ex;
        logic [31:0] r_rne;
        logic [31:0] r_tr;
        logic        o_rne;
        logic        o_tr;
    } vec_t;

    task automatic test_directed();
        vec_t tbl[10];
        exp_t e;
        int   lat;
        tbl[0] = '{49'h0400000000000, 49'h0,             1'b0, 9'd127, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0};
        tbl[1] = '{49'h0800000000000, 49'h0100000000000, 1'b0, 9'd127, 32'h40100000, 32'h40100000, 1'b0, 1'b0};
        tbl[2] = '{49'h0400000C00000, 49'h0,             1'b0, 9'd127, 32'h3F800002, 32'h3F800001, 1'b0, 1'b0};
        tbl[3] = '{49'h0800000000000, 49'h0100000000000, 1'b0, 9'd254, 32'h7F800000, 32'h7F800000, 1'b1, 1'b1};
        tbl[4] = '{49'h0,             49'h0,             1'b1, 9'd127, 32'h80000000, 32'h80000000, 1'b0, 1'b0};
        tbl[5] = '{49'h07FFFFFC00000, 49'h0,             1'b0, 9'd127, 32'h40000000, 32'h3FFFFFFF, 1'b0, 1'b0};
        tbl[6] = '{49'h0400000000000, 49'h0,             1'b1, 9'd0,   32'h80000000, 32'h80000000, 1'b0, 1'b0};
        tbl[7] = '{49'h0200000000000, 49'h0,             1'b0, 9'd127, 32'h3FC00000, 32'h3FC00000, 1'b0, 1'b0};
        tbl[8] = '{49'h07FFFFFC00000, 49'h0,             1'b0, 9'd254, 32'h7F800000, 32'h7F7FFFFF, 1'b1, 1'b0};
        tbl[9] = '{49'h1400000000000, 49'h0,             1'b1, 9'd127, 32'hBF800000, 32'hBF800000, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            clear_pp();
            pp_drv[0] = tbl[i].pa;
            pp_drv[5] = tbl[i].pb;
`ifdef PP_SUM_RNE_EN
            sb.push_back('{res: tbl[i].r_rne, ovf: tbl[i].o_rne});
`else
            sb.push_back('{res: tbl[i].r_tr, ovf: tbl[i].o_tr});
`endif
            send(tbl[i].s, tbl[i].ex);
            wait_out(lat);
            checks++;
            if (lat != 14) begin
                errors++;
                $display("FAIL dir%0d_latency got %0d want 14", i, lat);
            end
            e = sb.pop_front();
            checks++;
            if ({result, ovf} !== {e.res, e.ovf}) begin
                errors++;
                $display("FAIL dir%0d_result got %h ovf %b want %h ovf %b",
                         i, result, ovf, e.res, e.ovf);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        exp_t e;
        int   lat;
        logic s;
        logic [8:0] ex;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 13; i++)
                pp_drv[i] = {$urandom, $urandom} >> $urandom_range(15, 24);
            s  = 1'($urandom_range(0, 1));
            ex = 9'($urandom_range(1, 253));
            sb.push_back(model(s, ex));
            send(s, ex);
            wait_out(lat);
            e = sb.pop_front();
            checks++;
            if (lat != 14 || {result, ovf} !== {e.res, e.ovf}) begin
                errors++;
                $display("FAIL rand%0d got %h ovf %b lat %0d want %h ovf %b lat 14",
                         k, result, ovf, lat, e.res, e.ovf);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        int unsigned c1, c2;
        clear_pp();
        pp_drv[0] = 49'h0800000000000;
        pp_drv[7] = 49'h0100000000000;
        sb.push_back(model(1'b0, 9'd127));
        send(1'b0, 9'd127);
        wait_out(lat);
        c1 = cyc;
        e  = sb.pop_front();
        checks++;
        if ({result, ovf} !== {e.res, e.ovf}) begin
            errors++;
            $display("FAIL b2b_first got %h want %h", result, e.res);
        end
        // Second operation is offered while the first is still in OUT
        clear_pp();
        pp_drv[3] = 49'h0400000000000;
        sb.push_back(model(1'b1, 9'd100));
        send(1'b1, 9'd100);
        wait_out(lat);
        c2 = cyc;
        e  = sb.pop_front();
        checks++;
        if ({result, ovf} !== {e.res, e.ovf}) begin
            errors++;
            $display("FAIL b2b_second got %h want %h", result, e.res);
        end
        checks++;
        if (c2 - c1 != 16) begin
            errors++;
            $display("FAIL b2b_spacing got %0d want 16", c2 - c1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   lat;
        int   bad;
        clear_pp();
        pp_drv[0] = 49'h0800000000000;
        pp_drv[5] = 49'h0100000000000;
        out_ready = 1'b0;
        sb.push_back('{res: 32'h40100000, ovf: 1'b0});
        send(1'b0, 9'd127);
        wait_out(lat);
        e = sb.pop_front();
        checks++;
        if ({result, ovf} !== {e.res, e.ovf} || lat != 14) begin
            errors++;
            $display("FAIL bp_result got %h lat %0d want %h lat 14", result, lat, e.res);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            pp_drv[0] = 49'h0400000000000;
            in_valid  = (i % 2 == 0);
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                result !== e.res || ovf !== e.ovf) bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold got %0d bad cycles want 0 (res %h vld %b rdy %b)",
                     bad, result, out_valid, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got vld %b rdy %b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_acc();
        exp_t e;
        int   lat;
        int   seen;
        clear_pp();
        pp_drv[0] = 49'h0800000000000;
        pp_drv[5] = 49'h0100000000000;
        send(1'b0, 9'd127);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_abort got vld %b rdy %b want 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_no_partial got %0d valid cycles want 0", seen);
        end
        clear_pp();
        pp_drv[0] = 49'h0400000000000;
        sb.push_back('{res: 32'h3F800000, ovf: 1'b0});
        send(1'b0, 9'd127);
        wait_out(lat);
        e = sb.pop_front();
        checks++;
        if ({result, ovf} !== {e.res, e.ovf} || lat != 14) begin
            errors++;
            $display("FAIL rst_recover got %h lat %0d want %h lat 14", result, lat, e.res);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_acc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
